// File: rtl/serial_subtractor_16bit.sv
// Multi-cycle subtractor: A - B - borrow_in, one DIGIT-wide slice per clock, LSD first.
// Optional signed-overflow flag enabled with `define SUB_OVERFLOW_EN.
module serial_subtractor_16bit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; ready never depends combinationally on valid on either side.
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic             borrow_q, borrow_out_q;
  logic [DIGIT-1:0] a_s, b_s, d_s;
  logic             bout_s;
  logic             accept, consume, last;

  assign accept    = (state == IDLE) && in_valid;
  assign consume   = (state == DONE) && out_ready;
  assign last      = (idx == IW'(NDIG - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign borrow_out = borrow_out_q;

  // One digit slice of the subtract, fed only from registered state.
  always_comb begin
    a_s = a_q[idx*DIGIT +: DIGIT];
    b_s = b_q[idx*DIGIT +: DIGIT];
    {bout_s, d_s} = {1'b0, a_s} - {1'b0, b_s} - {{DIGIT{1'b0}}, borrow_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = BUSY;
      BUSY:    if (last)    state_nxt = DONE;
      DONE:    if (consume) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= borrow_in;
            idx      <= '0;
          end
        end
        BUSY: begin
          diff_q[idx*DIGIT +: DIGIT] <= d_s;
          borrow_q <= bout_s;
          if (last) begin
            idx          <= '0;
            borrow_out_q <= bout_s;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_OVERFLOW_EN
  logic overflow_q;

  // The top digit is computed on the last BUSY cycle, so its MSB is the result sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (state == BUSY && last) begin
      overflow_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_s[DIGIT-1] != a_q[WIDTH-1]);
    end
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Directed bench for serial_subtractor_16bit: latency, wrap-around, digit borrow ripple,
// backpressure and mid-operation reset, with immediate assertions at each check.
module tb_serial_subtractor_16bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        borrow_in = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        in_ready, out_valid, borrow_out;
  logic [15:0] diff;
`ifdef SUB_OVERFLOW_EN
  logic        overflow;
`endif

  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q[$];  // {overflow, borrow_out, diff}

  serial_subtractor_16bit #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .borrow_in(borrow_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff(diff),
    .borrow_out(borrow_out)
`ifdef SUB_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands and let them be taken on the next rising edge.
  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bin,
                          input logic [15:0] exp_d, input logic exp_b, input logic exp_ov);
    @(negedge clk);
    a = av;
    b = bv;
    borrow_in = bin;
    in_valid = 1'b1;
    exp_q.push_back({exp_ov, exp_b, exp_d});
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~av;
    b = ~bv;
    borrow_in = ~bin;
  endtask

  task automatic wait_result(input string tag);
    int lat;
    logic [17:0] e;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) check({tag, "_busy_in_ready"}, in_ready, 0);
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, lat, 4);
    e = exp_q.pop_front();
    check({tag, "_diff"}, diff, e[15:0]);
    check({tag, "_borrow_out"}, borrow_out, e[16]);
`ifdef SUB_OVERFLOW_EN
    check({tag, "_overflow"}, overflow, e[17]);
`endif
  endtask

  task automatic consume(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_consumed_out_valid"}, out_valid, 0);
    check({tag, "_consumed_in_ready"}, in_ready, 1);
  endtask

  initial begin
    // Reset state
    #2;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_diff", diff, 0);
    check("reset_borrow_out", borrow_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // out_ready high while idle must not matter
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    start_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    wait_result("basic");
    consume("basic");

    start_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    wait_result("wrap");
    consume("wrap");

    start_op(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    wait_result("wrap_bin");
    consume("wrap_bin");

    start_op(16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0, 1'b0);
    wait_result("ripple");
    consume("ripple");

    start_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    wait_result("ovf_neg");
    consume("ovf_neg");

    start_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    wait_result("ovf_pos");
    consume("ovf_pos");

    // Backpressure: result held while new operands are offered
    start_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    wait_result("bp");
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'h0000;
    borrow_in = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_diff", diff, 16'h0002);
      check("bp_hold_borrow", borrow_out, 0);
      check("bp_hold_in_ready", in_ready, 0);
      check("bp_hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    consume("bp");
    start_op(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    wait_result("after_bp");
    consume("after_bp");

    // Reset during BUSY at digit index 2
    start_op(16'h1234, 16'h1111, 1'b0, 16'h0123, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_reset_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_diff", diff, 0);
    check("midrst_borrow_out", borrow_out, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);
    wait_result("post_rst");
    consume("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
